// File: rtl/clock_enable_sequencer.sv
// One-hot phase ring with per-output tap masks, an optional bounded stretch at
// HOLD_PHASE, and self-recovery from corrupted (non-one-hot) ring states.
module clock_enable_sequencer #(
    parameter int PHASES      = 12,
    parameter int NUM_EN      = 6,
    parameter logic [NUM_EN*PHASES-1:0] TAP_MASK = {12'h200, 12'h040, 12'h008,
                                                    12'h001, 12'h249, 12'hAAA},
    parameter int RESET_PHASE = 3,
    parameter int HOLD_PHASE  = 0,
    parameter int MAX_STRETCH = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stretch_req,
    output logic [NUM_EN-1:0]         en,
    output logic [PHASES-1:0]         phase,
    output logic [PHASES-1:0]         phase_next,
    output logic [$clog2(PHASES)-1:0] phase_idx,
    output logic                      stretched,
    output logic                      stretch_timeout,
    output logic                      ring_fault
);

    localparam int IDX_W = $clog2(PHASES);
    localparam int CNT_W = (MAX_STRETCH < 1) ? 1 : $clog2(MAX_STRETCH + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_STRETCH);
    localparam logic [PHASES-1:0] RESET_VEC = PHASES'(1) << RESET_PHASE;

    logic [PHASES-1:0] phase_reg;
    logic [NUM_EN-1:0] en_reg;
    logic              stretched_reg;
    logic              timeout_reg;
    logic              fault_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic [NUM_EN-1:0] taps;
    logic [PHASES-1:0] rotated;
    logic [6:0]        ones;
    logic              one_hot;
    logic              hold;
    logic              force_release;
    logic [IDX_W-1:0]  idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_EN; gi++) begin : g_tap
            assign taps[gi] = |(phase_reg & TAP_MASK[gi*PHASES +: PHASES]);
        end
    endgenerate

    always_comb begin
        ones = 7'd0;
        idx  = '0;
        for (int k = 0; k < PHASES; k++) begin
            ones = ones + {6'd0, phase_reg[k]};
            if (phase_reg[k]) idx = idx | IDX_W'(k);
        end
        one_hot = (ones == 7'd1);
        if (!one_hot) idx = '0;
    end

    assign rotated = {phase_reg[PHASES-2:0], phase_reg[PHASES-1]};

    // Stretch logic disappears entirely when MAX_STRETCH is zero.
    generate
        if (MAX_STRETCH > 0) begin : g_hold
            logic at_hold;
            assign at_hold       = phase_reg[HOLD_PHASE] & stretch_req;
            assign hold          = at_hold & (cnt_reg < MAX_CNT);
            assign force_release = at_hold & (cnt_reg == MAX_CNT);
        end else begin : g_no_hold
            assign hold          = 1'b0;
            assign force_release = 1'b0;
        end
    endgenerate

    always_comb begin
        phase_next = rotated;
        if (!one_hot)  phase_next = RESET_VEC;
        else if (hold) phase_next = phase_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_reg     <= RESET_VEC;
            en_reg        <= '0;
            stretched_reg <= 1'b0;
            timeout_reg   <= 1'b0;
            fault_reg     <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            phase_reg <= phase_next;
            if (!one_hot) begin
                en_reg        <= '0;
                stretched_reg <= 1'b0;
                timeout_reg   <= 1'b0;
                fault_reg     <= 1'b1;
                cnt_reg       <= '0;
            end else begin
                // Taps fire only on the first cycle of a held phase.
                en_reg        <= stretched_reg ? '0 : taps;
                stretched_reg <= hold;
                timeout_reg   <= force_release;
                fault_reg     <= 1'b0;
                cnt_reg       <= hold ? cnt_reg + CNT_W'(1) : '0;
            end
        end
    end

    assign en              = en_reg;
    assign phase           = phase_reg;
    assign phase_idx       = idx;
    assign stretched       = stretched_reg;
    assign stretch_timeout = timeout_reg;
    assign ring_fault      = fault_reg;

endmodule

// File: tb/tb_clock_enable_sequencer.sv
// Directed bench for clock_enable_sequencer: default 12-phase ring plus an
// 8-phase, 2-output instance sharing the clock and reset.
module tb_clock_enable_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stretch_req = 1'b0;
    logic [5:0]  en;
    logic [11:0] phase;
    logic [11:0] phase_next;
    logic [3:0]  phase_idx;
    logic        stretched;
    logic        stretch_timeout;
    logic        ring_fault;

    logic        req2 = 1'b0;
    logic [1:0]  en2;
    logic [7:0]  phase2;
    logic [7:0]  phase_next2;
    logic [2:0]  phase_idx2;
    logic        stretched2;
    logic        timeout2;
    logic        fault2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    clock_enable_sequencer dut (
        .clk(clk), .rst(rst), .stretch_req(stretch_req), .en(en), .phase(phase),
        .phase_next(phase_next), .phase_idx(phase_idx), .stretched(stretched),
        .stretch_timeout(stretch_timeout), .ring_fault(ring_fault)
    );

    clock_enable_sequencer #(
        .PHASES(8), .NUM_EN(2), .TAP_MASK({8'h10, 8'h01}),
        .RESET_PHASE(3), .HOLD_PHASE(0), .MAX_STRETCH(15)
    ) dut8 (
        .clk(clk), .rst(rst), .stretch_req(req2), .en(en2), .phase(phase2),
        .phase_next(phase_next2), .phase_idx(phase_idx2), .stretched(stretched2),
        .stretch_timeout(timeout2), .ring_fault(fault2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input int b, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (phase[b]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (phase !== 12'h008) begin n_err++; $display("FAIL reset_phase got %h want 008", phase); end
        n_cmp++; if (en !== 6'b0) begin n_err++; $display("FAIL reset_en got %b want 000000", en); end
        n_cmp++; if ({stretched, stretch_timeout, ring_fault} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags got %b want 000", {stretched, stretch_timeout, ring_fault}); end
        n_cmp++; if (phase_idx !== 4'd3) begin n_err++; $display("FAIL reset_idx got %0d want 3", phase_idx); end
        n_cmp++; if (phase_next !== 12'h010) begin n_err++; $display("FAIL reset_next got %h want 010", phase_next); end
        tick(); tick();
        n_cmp++; if (phase !== 12'h008 || en !== 6'b0) begin
            n_err++; $display("FAIL reset_held got phase %h en %b want 008 000000", phase, en); end
        @(negedge clk);
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_free_run;
        int cnt[6];
        int lastq, per;
        lastq = -1; per = 0;
        for (int k = 0; k < 6; k++) cnt[k] = 0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (i == 1) begin
                n_cmp++; if (en !== 6'b001011) begin n_err++; $display("FAIL first_en got %b want 001011", en); end
                n_cmp++; if (phase !== 12'h010) begin n_err++; $display("FAIL first_phase got %h want 010", phase); end
            end
            for (int k = 0; k < 6; k++) if (en[k]) cnt[k]++;
            if (en[2]) begin
                if (lastq >= 0) per = i - lastq;
                lastq = i;
            end
        end
        n_cmp++; if (cnt[0] !== 12) begin n_err++; $display("FAIL count_en0 got %0d want 12", cnt[0]); end
        n_cmp++; if (cnt[1] !== 8) begin n_err++; $display("FAIL count_en1 got %0d want 8", cnt[1]); end
        for (int k = 2; k < 6; k++) begin
            n_cmp++; if (cnt[k] !== 2) begin n_err++; $display("FAIL count_en%0d got %0d want 2", k, cnt[k]); end
        end
        n_cmp++; if (per !== 12) begin n_err++; $display("FAIL free_period got %0d want 12", per); end
        $display("test_free_run done");
    endtask

    task automatic test_param_sweep;
        int lastq, per, n0;
        lastq = -1; per = 0; n0 = 0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (en2[0]) begin
                n0++;
                if (lastq >= 0) per = i - lastq;
                lastq = i;
            end
        end
        n_cmp++; if (per !== 8) begin n_err++; $display("FAIL sweep_period got %0d want 8", per); end
        n_cmp++; if (n0 !== 3) begin n_err++; $display("FAIL sweep_count got %0d want 3", n0); end
        $display("test_param_sweep done");
    endtask

    task automatic test_stretch_short;
        bit ok;
        int per, nstr;
        per = 0; nstr = 0;
        stretch_req = 1'b0;
        wait_phase(0, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL short_wait got timeout want phase0"); end
        stretch_req = 1'b1;
        tick();
        n_cmp++; if (phase !== 12'h001 || stretched !== 1'b1 || en !== 6'b000110) begin
            n_err++; $display("FAIL short_s1 got phase %h str %b en %b want 001 1 000110", phase, stretched, en); end
        nstr++;
        tick();
        n_cmp++; if (phase !== 12'h001 || stretched !== 1'b1 || en !== 6'b0) begin
            n_err++; $display("FAIL short_s2 got phase %h str %b en %b want 001 1 000000", phase, stretched, en); end
        nstr++;
        tick();
        n_cmp++; if (phase !== 12'h001 || stretched !== 1'b1 || en !== 6'b0) begin
            n_err++; $display("FAIL short_s3 got phase %h str %b en %b want 001 1 000000", phase, stretched, en); end
        nstr++;
        stretch_req = 1'b0;
        tick();
        n_cmp++; if (phase !== 12'h002 || stretched !== 1'b0 || en !== 6'b0) begin
            n_err++; $display("FAIL short_s4 got phase %h str %b en %b want 002 0 000000", phase, stretched, en); end
        for (int i = 5; i <= 20; i++) begin
            tick();
            if (stretched) nstr++;
            if (en[2] && per == 0) per = i - 1;
        end
        n_cmp++; if (per !== 15) begin n_err++; $display("FAIL short_period got %0d want 15", per); end
        n_cmp++; if (nstr !== 3) begin n_err++; $display("FAIL short_stretched got %0d want 3", nstr); end
        $display("test_stretch_short done");
    endtask

    task automatic test_stretch_off_phase;
        bit ok;
        int lastq, per, nstr;
        lastq = -1; per = 0; nstr = 0;
        stretch_req = 1'b0;
        wait_phase(5, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL off_wait got timeout want phase5"); end
        for (int i = 1; i <= 30; i++) begin
            stretch_req = phase[5];
            tick();
            if (stretched) nstr++;
            if (en[2]) begin
                if (lastq >= 0) per = i - lastq;
                lastq = i;
            end
        end
        stretch_req = 1'b0;
        n_cmp++; if (nstr !== 0) begin n_err++; $display("FAIL off_stretched got %0d want 0", nstr); end
        n_cmp++; if (per !== 12) begin n_err++; $display("FAIL off_period got %0d want 12", per); end
        $display("test_stretch_off_phase done");
    endtask

    task automatic test_stretch_stuck;
        bit ok;
        int run, nruns, bad_run, nto, nq, lastq, bad_per, str_run, bad_str;
        run = 1; nruns = 0; bad_run = 0; nto = 0; nq = 0; lastq = -1; bad_per = 0;
        str_run = 0; bad_str = 0;
        stretch_req = 1'b0;
        wait_phase(0, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL stuck_wait got timeout want phase0"); end
        stretch_req = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (stretched) str_run++;
            if (stretch_timeout) nto++;
            if (phase[0]) run++;
            else if (run > 0) begin
                nruns++;
                if (run != 16) bad_run++;
                if (str_run != 15) bad_str++;
                run = 0;
                str_run = 0;
            end
            if (en[2]) begin
                nq++;
                if (lastq >= 0 && i - lastq != 27) bad_per++;
                lastq = i;
            end
        end
        stretch_req = 1'b0;
        n_cmp++; if (nruns !== 2 || bad_run !== 0) begin
            n_err++; $display("FAIL stuck_runs got %0d runs %0d bad want 2 runs of 16", nruns, bad_run); end
        n_cmp++; if (bad_str !== 0) begin n_err++; $display("FAIL stuck_str_per_visit got %0d bad want 0", bad_str); end
        n_cmp++; if (nto !== 2) begin n_err++; $display("FAIL stuck_timeouts got %0d want 2", nto); end
        n_cmp++; if (nq !== 3 || bad_per !== 0) begin
            n_err++; $display("FAIL stuck_period got %0d pulses %0d bad want 3 pulses period 27", nq, bad_per); end
        $display("test_stretch_stuck done");
    endtask

    task automatic fault_case(input logic [11:0] bad);
        @(negedge clk);
        force dut.phase_reg = bad;
        #1;
        release dut.phase_reg;
        #1;
        n_cmp++; if (phase_next !== 12'h008 || phase_idx !== 4'd0) begin
            n_err++; $display("FAIL fault_next(%h) got next %h idx %0d want 008 0", bad, phase_next, phase_idx); end
        tick();
        n_cmp++; if (ring_fault !== 1'b1 || phase !== 12'h008 || en !== 6'b0) begin
            n_err++; $display("FAIL fault_hit(%h) got flt %b phase %h en %b want 1 008 000000", bad, ring_fault, phase, en); end
        tick();
        n_cmp++; if (ring_fault !== 1'b0 || phase !== 12'h010 || en !== 6'b001011) begin
            n_err++; $display("FAIL fault_after(%h) got flt %b phase %h en %b want 0 010 001011", bad, ring_fault, phase, en); end
    endtask

    task automatic test_ring_fault;
        stretch_req = 1'b0;
        fault_case(12'h000);
        fault_case(12'h082);
        $display("test_ring_fault done");
    endtask

    task automatic test_reset_mid_stretch;
        bit ok;
        stretch_req = 1'b0;
        wait_phase(0, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL mid_wait got timeout want phase0"); end
        stretch_req = 1'b1;
        tick(); tick();
        n_cmp++; if (stretched !== 1'b1) begin n_err++; $display("FAIL mid_pre got str %b want 1", stretched); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (phase !== 12'h008 || en !== 6'b0 || phase_idx !== 4'd3 ||
                     {stretched, stretch_timeout, ring_fault} !== 3'b000) begin
            n_err++; $display("FAIL mid_async got phase %h en %b idx %0d flags %b want 008 000000 3 000",
                              phase, en, phase_idx, {stretched, stretch_timeout, ring_fault}); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_cmp++; if (phase !== 12'h010 || en !== 6'b001011 || stretched !== 1'b0) begin
            n_err++; $display("FAIL mid_resume got phase %h en %b str %b want 010 001011 0", phase, en, stretched); end
        stretch_req = 1'b0;
        $display("test_reset_mid_stretch done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_free_run();
        test_param_sweep();
        test_stretch_short();
        test_stretch_off_phase();
        test_stretch_stuck();
        test_ring_fault();
        test_reset_mid_stretch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
